// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache between the CPU
//   load/store path and a word-organised data memory. Blocks are 4 bytes;
//   2^INDEX_W blocks; tag is the remaining 6-INDEX_W bits of the block address.
//
// Ports
//   CLK, RESET          clock (rising edge), asynchronous active-low reset
//   READ, WRITE         CPU load / store request (held while BUSYWAIT=1)
//   ADDRESS[7:0]        byte address {tag, index, offset[1:0]}
//   WRITEDATA[7:0]      store byte
//   READDATA[7:0]       load byte (holds last value when READ=0)
//   BUSYWAIT            CPU stall
//   MEM_READ/MEM_WRITE  block fetch / write-back request
//   MEM_ADDRESS[5:0]    block address {tag, index}
//   MEM_WRITEDATA[31:0] block written back (byte 0 in [7:0])
//   MEM_READDATA[31:0]  fetched block
//   MEM_BUSYWAIT        memory busy while a request is in progress
//
// Optional build macro DCACHE_STATS_EN adds HIT_COUNT[15:0] and
// MISS_COUNT[15:0] saturating counters.
module dcache_controller #(
  parameter int unsigned INDEX_W = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int unsigned TAG_W = 6 - INDEX_W;
  localparam int unsigned NBLK  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_UPDATE
  } state_e;

  state_e state_q, state_d;

  logic [NBLK-1:0]  valid_q, valid_d;
  logic [NBLK-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [NBLK];
  logic [TAG_W-1:0] tag_d  [NBLK];
  logic [31:0]      data_q [NBLK];
  logic [31:0]      data_d [NBLK];
  logic [31:0]      fill_q, fill_d;
  logic [7:0]       readdata_q, readdata_d;

  logic [1:0]         offset;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   addr_tag;
  logic               req;
  logic               hit;
  logic               idle_hit;
  logic [7:0]         sel_byte;
  logic               mem_read;
  logic               mem_write;
  logic [5:0]         mem_addr;

  assign offset   = ADDRESS[1:0];
  assign idx      = ADDRESS[INDEX_W+1:2];
  assign addr_tag = ADDRESS[7:INDEX_W+2];
  assign req      = READ | WRITE;
  assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign idle_hit = (state_q == S_IDLE) && hit;
  assign sel_byte = data_q[idx][{offset, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    data_d    = data_q;
    fill_d    = fill_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {addr_tag, idx};
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            // WRITE wins when both requests are (illegally) high.
            if (WRITE) begin
              data_d[idx][{offset, 3'b000} +: 8] = WRITEDATA;
              dirty_d[idx] = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[idx], idx};
        if (!MEM_BUSYWAIT) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_d  = MEM_READDATA;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        data_d[idx]  = fill_q;
        tag_d[idx]   = addr_tag;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load data is combinational on a hit and otherwise holds the last value.
  always_comb begin
    readdata_d = readdata_q;
    if (READ && idle_hit) readdata_d = sel_byte;
  end

  // Outputs gated by RESET so an abandoned transaction drops in the same delta.
  assign READDATA      = RESET ? readdata_d : '0;
  assign BUSYWAIT      = RESET && req && !idle_hit;
  assign MEM_READ      = RESET && mem_read;
  assign MEM_WRITE     = RESET && mem_write;
  assign MEM_ADDRESS   = mem_addr;
  assign MEM_WRITEDATA = data_q[idx];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      readdata_q <= readdata_d;
    end
  end

  // Tags, data and the fill buffer carry no reset value.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    fill_q <= fill_d;
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q, retry_d;
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // The hit that completes a refilled access follows UPDATE and is not counted.
  always_comb begin
    retry_d      = (state_q == S_UPDATE);
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE && req) begin
      if (hit) begin
        if (!retry_q && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else if (miss_count_q != 16'hFFFF) begin
        miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      retry_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      retry_q      <= retry_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU's load/store path and the word-organised data memory.
- Serves byte accesses from the CPU, and stalls the CPU through BUSYWAIT while it sequences block write-back and fetch with memory.
- Memory is shared between write-back and refill under one FSM; only one memory transaction is outstanding at a time.

Parameters:
- INDEX_W, 3, index bits; 2^INDEX_W blocks. Block is fixed at 4 bytes, offset is 2 bits, TAG_W = 6 - INDEX_W.

Ports:
- CLK  in  1  clock; all state changes occur on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request; held stable while BUSYWAIT=1.
- WRITE  in  1  CPU store request; held stable while BUSYWAIT=1.
- ADDRESS  in  8  byte address: {tag, index, offset[1:0]}.
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  block written back; byte 0 is in [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; high while a request is in progress.

Behaviour:
- Storage per block: valid, dirty, tag[TAG_W-1:0], data[31:0].
- Hit = valid[idx] && tag[idx]==ADDRESS tag.
- Reset (RESET low, asynchronous):
  - All valid and dirty bits cleared; state = IDLE.
  - MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0, READDATA=0.
  - Tags and data are don't-care.
  - Reset mid-transaction abandons it immediately; the memory request drops in the same delta.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - Read hit: READDATA = selected byte, combinational; BUSYWAIT=0; zero stall cycles.
  - Write hit: byte written and dirty set at the next edge; BUSYWAIT=0.
  - Miss with valid && dirty: go to WRITEBACK.
  - Miss otherwise: go to FETCH.
  - No request: remain in IDLE.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, idx}, MEM_WRITEDATA=data[idx].
  - At the first edge with MEM_BUSYWAIT=0, go to FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS tag, idx}.
  - At the first edge with MEM_BUSYWAIT=0, go to UPDATE.
  - MEM_READDATA is sampled on that same edge.
- UPDATE (one cycle): data[idx] = captured block, tag written, valid=1, dirty=0. Next state IDLE, where the access now hits and completes.
- BUSYWAIT = (READ|WRITE) && !(state==IDLE && hit). Asserted combinationally in the request's first cycle on a miss.
- MEM_READ and MEM_WRITE are never both high; both are 0 outside FETCH and WRITEBACK.
- The memory contract: MEM_BUSYWAIT rises combinationally with MEM_READ/MEM_WRITE and stays high until the transfer is done.
- READ and WRITE both high is illegal. WRITE has priority; READDATA is still driven.
- READDATA holds its last value when READ=0.
- Miss latency is at least 3 cycles (FETCH, UPDATE, hit). A dirty miss adds the WRITEBACK cycles.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, two output ports are added: HIT_COUNT[15:0] and MISS_COUNT[15:0].
  - Both are cleared by reset and saturate at 16'hFFFF.
  - HIT_COUNT increments once per request that completes in IDLE on first sight with no prior miss.
  - MISS_COUNT increments once per IDLE->WRITEBACK/FETCH transition.
  - The retry-hit after UPDATE does not count as a hit.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then READ ADDRESS=8'h14 (clean miss), memory busy 5 cycles, returns 32'hDDCCBBAA.
  - Required: MEM_READ with MEM_ADDRESS=6'h05.
  - Required: READDATA=8'hAA after UPDATE; BUSYWAIT drops in the hit cycle.
- Then READ 8'h17.
  - Required: READDATA=8'hDD in the same cycle, BUSYWAIT=0, no memory request.
- WRITE 8'h15 with WRITEDATA 8'h5A, then READ 8'h34 (same index, tag differs, dirty).
  - Required: MEM_WRITE with MEM_ADDRESS=6'h05 and MEM_WRITEDATA=32'hDDCC5AAA.
  - Required: then MEM_READ with MEM_ADDRESS=6'h0D.
- WRITE-miss to 8'h40.
  - Required: fetch of block 6'h10, then the byte is written, dirty=1, and no second memory transaction.
- Drive RESET low during FETCH.
  - Required: MEM_READ=0 and BUSYWAIT=0 immediately.
  - Required: a later READ 8'h14 misses again because valid was cleared.
- With DCACHE_STATS_EN, run the sequence above.
  - Required: HIT_COUNT and MISS_COUNT match the scoreboard.
  - Required: the counter forced to 16'hFFFF stays at 16'hFFFF on the next hit.
